// File: rtl/alu_pkg.sv
// Shared ALU function codes, MIPS opcode/funct constants and issue FSM encoding.
package alu_pkg;

  // ALU function codes; 0110 and 1010 are reserved and never issued.
  localparam logic [3:0] FUNC_AND  = 4'b0000;
  localparam logic [3:0] FUNC_ADD  = 4'b0010;
  localparam logic [3:0] FUNC_SUB  = 4'b0100;
  localparam logic [3:0] FUNC_RSV6 = 4'b0110;
  localparam logic [3:0] FUNC_OR   = 4'b1000;
  localparam logic [3:0] FUNC_RSVA = 4'b1010;
  localparam logic [3:0] FUNC_XOR  = 4'b1100;
  localparam logic [3:0] FUNC_SLL  = 4'b1110;
  localparam logic [3:0] FUNC_NOP  = 4'b0001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode into ALU function, operands, destination and illegal flag.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit SHAMT_FROM_INSTR = 1'b1
) (
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  func,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  dest,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};
  // rs is supplied already read as rs_data.
  assign unused_rs_field = ^instr[25:21];

  always_comb begin
    func    = FUNC_NOP;
    op_a    = 32'h0;
    op_b    = 32'h0;
    dest    = 5'd0;
    illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        illegal = 1'b0;
        op_a    = rs_data;
        op_b    = rt_data;
        dest    = instr[15:11];
        case (funct)
          FN_AND:           func = FUNC_AND;
          FN_ADD, FN_ADDU:  func = FUNC_ADD;
          FN_SUB, FN_SUBU:  func = FUNC_SUB;
          FN_OR:            func = FUNC_OR;
          FN_XOR:           func = FUNC_XOR;
          FN_SLL: begin
            func = FUNC_SLL;
            op_a = rt_data;
            op_b = SHAMT_FROM_INSTR ? {27'h0, instr[10:6]} : rs_data;
          end
          default: begin
            func    = FUNC_NOP;
            op_a    = 32'h0;
            op_b    = 32'h0;
            dest    = 5'd0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        illegal = 1'b0;
        func    = FUNC_ADD;
        op_a    = rs_data;
        op_b    = imm_sext;
        dest    = instr[20:16];
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        illegal = 1'b0;
        func    = (opcode == OP_ANDI) ? FUNC_AND : (opcode == OP_ORI) ? FUNC_OR : FUNC_XOR;
        op_a    = rs_data;
        op_b    = imm_zext;
        dest    = instr[20:16];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, drives registered operands to an external
// ALU for one cycle, then holds the result until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter bit SHAMT_FROM_INSTR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  alu_func,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  input  logic [31:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  logic [1:0]  state_q;
  logic [3:0]  func_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [4:0]  rd_q;
  logic        illegal_q;
  logic [31:0] data_q;

  logic [3:0]  dec_func;
  logic [31:0] dec_op_a;
  logic [31:0] dec_op_b;
  logic [4:0]  dec_dest;
  logic        dec_illegal;

  alu_decode #(
    .SHAMT_FROM_INSTR(SHAMT_FROM_INSTR)
  ) u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .func    (dec_func),
    .op_a    (dec_op_a),
    .op_b    (dec_op_b),
    .dest    (dec_dest),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      func_q    <= FUNC_NOP;
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            func_q    <= dec_func;
            op_a_q    <= dec_op_a;
            op_b_q    <= dec_op_b;
            rd_q      <= dec_dest;
            illegal_q <= dec_illegal;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          data_q  <= illegal_q ? 32'h0 : alu_res;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_RESP);
  assign alu_func    = func_q;
  assign alu_op_a    = op_a_q;
  assign alu_op_b    = op_b_q;
  assign out_data    = data_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed table-driven bench for alu_issue_ctrl with a behavioural 32-bit ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  alu_func;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .alu_func    (alu_func),
    .alu_op_a    (alu_op_a),
    .alu_op_b    (alu_op_b),
    .alu_res     (alu_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  // Reference ALU driven by the controller's registered outputs.
  always_comb begin
    alu_res = 32'h0;
    case (alu_func)
      4'b0000: alu_res = alu_op_a & alu_op_b;
      4'b0010: alu_res = alu_op_a + alu_op_b;
      4'b0100: alu_res = alu_op_a - alu_op_b;
      4'b1000: alu_res = alu_op_a | alu_op_b;
      4'b1100: alu_res = alu_op_a ^ alu_op_b;
      4'b1110: alu_res = alu_op_a << alu_op_b[4:0];
      default: alu_res = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"add",   32'h00221820, 32'd5,        32'd7,      4'b0010, 32'd5,        32'd7,
                32'd12,        5'd3, 1'b0};
    vecs[1] = '{"sub",   32'h00222022, 32'd3,        32'd5,      4'b0100, 32'd3,        32'd5,
                32'hFFFFFFFE,  5'd4, 1'b0};
    vecs[2] = '{"addi",  32'h2022FFFF, 32'd0,        32'h1234,   4'b0010, 32'd0,        32'hFFFFFFFF,
                32'hFFFFFFFF,  5'd2, 1'b0};
    vecs[3] = '{"ori",   32'h34228000, 32'd0,        32'h1234,   4'b1000, 32'd0,        32'h00008000,
                32'h00008000,  5'd2, 1'b0};
    vecs[4] = '{"sll",   32'h00022900, 32'h55,       32'd1,      4'b1110, 32'd1,        32'd4,
                32'd16,        5'd5, 1'b0};
    vecs[5] = '{"and",   32'h00223024, 32'h0000F0F0, 32'hFF00,   4'b0000, 32'h0000F0F0, 32'hFF00,
                32'h0000F000,  5'd6, 1'b0};
    vecs[6] = '{"xori",  32'h382200FF, 32'h0F,       32'd9,      4'b1100, 32'h0F,       32'hFF,
                32'hF0,        5'd2, 1'b0};
    vecs[7] = '{"addu",  32'h00221821, 32'hFFFFFFFF, 32'd1,      4'b0010, 32'hFFFFFFFF, 32'd1,
                32'd0,         5'd3, 1'b0};
    vecs[8] = '{"lw",    32'h8C220000, 32'd5,        32'd7,      4'b0001, 32'd0,        32'd0,
                32'd0,         5'd0, 1'b1};
    vecs[9] = '{"slt",   32'h0022182A, 32'd5,        32'd7,      4'b0001, 32'd0,        32'd0,
                32'd0,         5'd0, 1'b1};
  end

  // Present an instruction in IDLE; returns after the accepting edge (+1).
  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
    @(posedge clk);
    #1;
    // Garbage on the inputs outside IDLE must not disturb the in-flight op.
    in_valid = 1'b1;
    instr    = 32'h00000020;
    rs_data  = 32'hDEADBEEF;
    rt_data  = 32'hCAFEF00D;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    rs_data   = 32'h0;
    rt_data   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'h0, in_ready}, 32'd1);
    check("rst out_valid", {31'h0, out_valid}, 32'd0);
    check("rst alu_func", {28'h0, alu_func}, 32'b0001);
    check("rst op_a", alu_op_a, 32'h0);
    check("rst op_b", alu_op_b, 32'h0);
    check("rst out_data", out_data, 32'h0);
    check("rst out_rd", {27'h0, out_rd}, 32'h0);
    check("rst out_illegal", {31'h0, out_illegal}, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Back-to-back table; out_ready high early must not shortcut EXEC.
    for (int k = 0; k < 10; k++) begin
      issue(vecs[k].instr, vecs[k].rs, vecs[k].rt);
      check({vecs[k].name, " exec in_ready"}, {31'h0, in_ready}, 32'd0);
      check({vecs[k].name, " exec out_valid"}, {31'h0, out_valid}, 32'd0);
      check({vecs[k].name, " func"}, {28'h0, alu_func}, {28'h0, vecs[k].func});
      check({vecs[k].name, " op_a"}, alu_op_a, vecs[k].op_a);
      check({vecs[k].name, " op_b"}, alu_op_b, vecs[k].op_b);
      @(posedge clk);
      #1;
      check({vecs[k].name, " out_valid"}, {31'h0, out_valid}, 32'd1);
      check({vecs[k].name, " out_data"}, out_data, vecs[k].data);
      check({vecs[k].name, " out_rd"}, {27'h0, out_rd}, {27'h0, vecs[k].rd});
      check({vecs[k].name, " out_illegal"}, {31'h0, out_illegal}, {31'h0, vecs[k].ill});
      check({vecs[k].name, " func held"}, {28'h0, alu_func}, {28'h0, vecs[k].func});
      // Result is handed over at edge N+2.
      @(posedge clk);
      #1;
      check({vecs[k].name, " back idle"}, {30'h0, in_ready, out_valid}, 32'b10);
      in_valid = 1'b0;
    end

    // Illegal op held in RESP while the consumer stalls.
    out_ready = 1'b0;
    issue(32'h8C220000, 32'd5, 32'd7);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall out_valid", {31'h0, out_valid}, 32'd1);
      check("stall in_ready", {31'h0, in_ready}, 32'd0);
      check("stall out_data", out_data, 32'h0);
      check("stall out_illegal", {31'h0, out_illegal}, 32'd1);
      check("stall func", {28'h0, alu_func}, 32'b0001);
      @(posedge clk);
    end
    #1;
    check("stall still valid", {31'h0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("stall release", {30'h0, in_ready, out_valid}, 32'b10);

    // Reset while EXEC drops the in-flight ADD.
    issue(32'h00221820, 32'd5, 32'd7);
    check("pre-rst func", {28'h0, alu_func}, 32'b0010);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("exec-rst in_ready", {31'h0, in_ready}, 32'd1);
    check("exec-rst out_valid", {31'h0, out_valid}, 32'd0);
    check("exec-rst func", {28'h0, alu_func}, 32'b0001);
    check("exec-rst op_a", alu_op_a, 32'h0);
    check("exec-rst out_data", out_data, 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("post-rst no valid", {31'h0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
